// File: rtl/sd_sampler_n.sv
// Discrete-input sampler: per-channel glitch filter feeding latched/transparent
// memory-latch bits, plus a snapshot serial readout of all channel states.
module sd_sampler_n #(
  parameter int CHANNELS = 2,
  parameter int SRC      = 8,
  parameter int FILT     = 2
) (
  input  logic                    SIM_CLK,
  input  logic                    SIM_RST,
  input  logic                    SAMPLE,
  input  logic [SRC-1:0]          SRC_EN,
  input  logic [CHANNELS*SRC-1:0] DINN,
  input  logic [CHANNELS-1:0]     MODE,
  input  logic                    CLR,
  input  logic                    RD_REQ,
  output logic [CHANNELS-1:0]     ML,
  output logic [CHANNELS-1:0]     MLN,
  output logic                    SD_OUT,
  output logic                    SD_VALID,
  output logic                    RD_BUSY,
  output logic                    RD_DONE
);

  localparam int CW = $clog2(FILT + 1);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(FILT);
  localparam logic [CW-1:0] CNT_QUAL = CW'(FILT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rd_state_t;

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] ml_next;
  logic [CW-1:0]       cnt [CHANNELS];

  rd_state_t           state, state_next;
  logic [CHANNELS-1:0] snap;
  logic [IW-1:0]       idx;

  // Lines are negative-true: a low line in an enabled slot is a hit.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c] = 1'b0;
      for (int s = 0; s < SRC; s++) begin
        raw[c] = raw[c] | (~DINN[c*SRC+s] & SRC_EN[s]);
      end
      qual[c] = SAMPLE & raw[c] & ((cnt[c] == CNT_QUAL) | (cnt[c] == CNT_MAX));
    end
  end

  // A qualifying set always beats a clear arriving in the same cycle.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ml_next[c] = ML[c];
      if (qual[c]) begin
        ml_next[c] = 1'b1;
      end else if (CLR || (!MODE[c] && SAMPLE && !raw[c])) begin
        ml_next[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
      ML  <= '0;
      MLN <= '1;
    end else begin
      if (SAMPLE) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (!raw[c]) begin
            cnt[c] <= '0;
          end else if (cnt[c] != CNT_MAX) begin
            cnt[c] <= cnt[c] + CW'(1);
          end
        end
      end
      ML  <= ml_next;
      MLN <= ~ml_next;
    end
  end

  // The snapshot is taken from the registered ML, so a same-cycle set is not seen.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && RD_REQ) begin
        snap <= ML;
        idx  <= '0;
      end else if (state == SHIFT) begin
        idx <= idx + IW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    SD_OUT     = 1'b0;
    SD_VALID   = 1'b0;
    RD_BUSY    = 1'b0;
    RD_DONE    = 1'b0;
    case (state)
      IDLE: begin
        if (RD_REQ) state_next = SHIFT;
      end
      SHIFT: begin
        SD_OUT   = snap[idx];
        SD_VALID = 1'b1;
        RD_BUSY  = 1'b1;
        if (idx == IDX_LAST) state_next = DONE;
      end
      DONE: begin
        RD_DONE    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_sampler_n.sv
// Directed self-checking bench for sd_sampler_n with four channels,
// eight sources and a two-sample filter.
module tb_sd_sampler_n;

  localparam int CH = 4;
  localparam int NS = 8;
  localparam int FL = 2;

  localparam logic [CH*NS-1:0] DIN_IDLE = 32'hFFFF_FFFF;
  localparam logic [CH*NS-1:0] CH0_S3   = 32'hFFFF_FFF7;
  localparam logic [CH*NS-1:0] CH0_S0   = 32'hFFFF_FFFE;
  localparam logic [CH*NS-1:0] CH1_S0   = 32'hFFFF_FEFF;
  localparam logic [CH*NS-1:0] CH13_S0  = 32'hFEFF_FEFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample;
  logic [NS-1:0]     src_en;
  logic [CH*NS-1:0]  dinn;
  logic [CH-1:0]     mode;
  logic              clr;
  logic              rd_req;
  logic [CH-1:0]     ml;
  logic [CH-1:0]     mln;
  logic              sd_out;
  logic              sd_valid;
  logic              rd_busy;
  logic              rd_done;

  int checks = 0;
  int errors = 0;

  logic [CH-1:0] exp_bits;

  always #5 clk = ~clk;

  sd_sampler_n #(.CHANNELS(CH), .SRC(NS), .FILT(FL)) dut (
    .SIM_CLK  (clk),
    .SIM_RST  (rst_n),
    .SAMPLE   (sample),
    .SRC_EN   (src_en),
    .DINN     (dinn),
    .MODE     (mode),
    .CLR      (clr),
    .RD_REQ   (rd_req),
    .ML       (ml),
    .MLN      (mln),
    .SD_OUT   (sd_out),
    .SD_VALID (sd_valid),
    .RD_BUSY  (rd_busy),
    .RD_DONE  (rd_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic smp, input logic [NS-1:0] en,
                               input logic [CH*NS-1:0] dn, input logic [CH-1:0] md,
                               input logic cl, input logic rq);
    sample = smp;
    src_en = en;
    dinn   = dn;
    mode   = md;
    clr    = cl;
    rd_req = rq;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'hFF, 32'h0, 4'hF, 1'b0, 1'b0);
    step(2);
    checkOutput("rst_ml", 32'(ml), 0);
    checkOutput("rst_mln", 32'(mln), 32'hF);
    checkOutput("rst_busy", 32'(rd_busy), 0);
    checkOutput("rst_valid", 32'(sd_valid), 0);
    checkOutput("rst_done", 32'(rd_done), 0);
    checkOutput("rst_sdout", 32'(sd_out), 0);

    // Filter start-up: one sample is not enough, the second qualifies.
    rst_n = 1'b1;
    step(1);
    checkOutput("first_sample", 32'(ml), 0);
    step(1);
    checkOutput("second_sample", 32'(ml), 32'hF);
    checkOutput("second_sample_mln", 32'(mln), 0);
    applyStimulus(1'b1, 8'hFF, DIN_IDLE, 4'hF, 1'b1, 1'b0);
    step(1);
    checkOutput("clr_all", 32'(ml), 0);

    // Glitch rejection on channel 0 source 3.
    applyStimulus(1'b1, 8'hFF, CH0_S3, 4'hF, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 8'hFF, DIN_IDLE, 4'hF, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 8'hFF, CH0_S3, 4'hF, 1'b0, 1'b0);
    step(1);
    checkOutput("glitch_single", 32'(ml), 0);
    step(1);
    checkOutput("two_consecutive", 32'(ml), 32'h1);
    applyStimulus(1'b1, 8'hFF, DIN_IDLE, 4'hF, 1'b1, 1'b0);
    step(1);
    checkOutput("glitch_clr", 32'(ml), 0);
    applyStimulus(1'b1, 8'hFE, CH0_S0, 4'hF, 1'b0, 1'b0);
    step(10);
    checkOutput("gated_source", 32'(ml), 0);

    // Latched channels 0/2, transparent channels 1/3.
    applyStimulus(1'b1, 8'hFF, 32'h0, 4'b0101, 1'b0, 1'b0);
    step(2);
    checkOutput("mode_qualify", 32'(ml), 32'hF);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'b0101, 1'b0, 1'b0);
    step(1);
    checkOutput("transp_no_sample", 32'(ml), 32'hF);
    applyStimulus(1'b1, 8'hFF, DIN_IDLE, 4'b0101, 1'b0, 1'b0);
    step(1);
    checkOutput("transp_release", 32'(ml), 32'h5);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'b0101, 1'b1, 1'b0);
    step(1);
    checkOutput("mode_clr", 32'(ml), 0);

    // Set beats clear; counter keeps its saturated value across the clear.
    applyStimulus(1'b1, 8'hFF, CH1_S0, 4'hF, 1'b0, 1'b0);
    step(1);
    checkOutput("coll_pre", 32'(ml), 0);
    applyStimulus(1'b1, 8'hFF, CH1_S0, 4'hF, 1'b1, 1'b0);
    step(1);
    checkOutput("coll_set_wins", 32'(ml), 32'h2);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'hF, 1'b1, 1'b0);
    step(1);
    checkOutput("clr_alone", 32'(ml), 0);
    applyStimulus(1'b1, 8'hFF, CH1_S0, 4'hF, 1'b0, 1'b0);
    step(1);
    checkOutput("saturated_requal", 32'(ml), 32'h2);
    applyStimulus(1'b1, 8'hFF, DIN_IDLE, 4'hF, 1'b0, 1'b0);
    step(1);
    checkOutput("latched_hold", 32'(ml), 32'h2);

    // Readout of 4'b1010 with a clear and an extra request mid-stream.
    applyStimulus(1'b1, 8'hFF, CH13_S0, 4'hF, 1'b0, 1'b0);
    step(2);
    checkOutput("ro_setup", 32'(ml), 32'hA);
    checkOutput("ro_idle_valid", 32'(sd_valid), 0);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'hF, 1'b0, 1'b1);
    step(1);
    exp_bits = 4'b1010;
    for (int i = 0; i < CH; i++) begin
      checkOutput("ro_valid", 32'(sd_valid), 1);
      checkOutput("ro_busy", 32'(rd_busy), 1);
      checkOutput("ro_bit", 32'(sd_out), 32'(exp_bits[i]));
      applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'hF, (i == 1), (i == 2));
      step(1);
    end
    checkOutput("ro_done", 32'(rd_done), 1);
    checkOutput("ro_done_busy", 32'(rd_busy), 0);
    checkOutput("ro_done_valid", 32'(sd_valid), 0);
    checkOutput("ro_done_sdout", 32'(sd_out), 0);
    checkOutput("ro_clr_applied", 32'(ml), 0);
    step(1);
    checkOutput("ro_req_ignored_done", 32'(rd_done), 0);
    checkOutput("ro_req_ignored_busy", 32'(rd_busy), 0);
    checkOutput("ro_req_ignored_valid", 32'(sd_valid), 0);

    // Reset in the middle of a readout.
    applyStimulus(1'b1, 8'hFF, CH13_S0, 4'hF, 1'b0, 1'b0);
    step(2);
    checkOutput("rst_ro_setup", 32'(ml), 32'hA);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'hF, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'hF, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b0;
    step(1);
    checkOutput("rst_ro_busy", 32'(rd_busy), 0);
    checkOutput("rst_ro_valid", 32'(sd_valid), 0);
    checkOutput("rst_ro_ml", 32'(ml), 0);
    checkOutput("rst_ro_mln", 32'(mln), 32'hF);
    checkOutput("rst_ro_done", 32'(rd_done), 0);
    rst_n = 1'b1;
    step(1);
    checkOutput("rst_no_done", 32'(rd_done), 0);
    checkOutput("rst_no_busy", 32'(rd_busy), 0);

    // Request in the same cycle as a set snapshots the old ML.
    applyStimulus(1'b1, 8'hFF, CH0_S3, 4'hF, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 8'hFF, CH0_S3, 4'hF, 1'b0, 1'b1);
    step(1);
    checkOutput("snap_ml_set", 32'(ml), 32'h1);
    applyStimulus(1'b0, 8'hFF, DIN_IDLE, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < CH; i++) begin
      checkOutput("snap_valid", 32'(sd_valid), 1);
      checkOutput("snap_bit", 32'(sd_out), 0);
      step(1);
    end
    checkOutput("snap_done", 32'(rd_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
